// File: rtl/lpm_constant_bank_if.sv
// ============================================================================
// Module   : lpm_constant_bank_if
// Brief    : Write-port bundle (valid/ready, channel, data, bit mask) for the
//            lpm_constant_bank register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lpm_constant_bank_if #(
    parameter int WIDTH  = 8,
    parameter int CHAN_W = 2
);
    logic              wr_valid;
    logic              wr_ready;
    logic [CHAN_W-1:0] wr_chan;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  wr_mask;

    modport master (
        output wr_valid,
        output wr_chan,
        output wr_data,
        output wr_mask,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_chan,
        input  wr_data,
        input  wr_mask,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/lpm_constant_bank.sv
// ============================================================================
// Module   : lpm_constant_bank
// Brief    : Bank of runtime-rewritable constants, preloaded from lpm_cvalue one
//            channel per cycle. Optional shadow copy with atomic commit when
//            LPM_CONSTANT_BANK_SHADOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpm_constant_bank #(
    parameter int                                lpm_width    = 8,
    parameter int                                lpm_channels = 4,
    parameter logic [lpm_width*lpm_channels-1:0] lpm_cvalue   = '0,
    parameter string                             lpm_type     = "lpm_constant_bank"
) (
    input  wire logic                              clock,
    input  wire logic                              reset_n,
    input  wire logic                              reload,
    input  wire logic                              commit,
    lpm_constant_bank_if.slave                     wr,
    output logic [lpm_width*lpm_channels-1:0]      result,
    output logic                                   busy,
    output logic                                   wr_err
);

    localparam int                CHAN_W   = (lpm_channels > 1) ? $clog2(lpm_channels) : 1;
    localparam logic [CHAN_W-1:0] IDX_LAST = CHAN_W'(lpm_channels - 1);
    localparam logic [CHAN_W:0]   NUM_CH   = (CHAN_W + 1)'(lpm_channels);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CHAN_W-1:0] idx;
    logic [CHAN_W-1:0] idx_nxt;
    logic              load;
    logic              accept;
    logic              chan_ok;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // reload in INIT restarts the sequence without loading that cycle
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            S_INIT: begin
                if (reload) begin
                    idx_nxt = '0;
                end else begin
                    load = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + CHAN_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (reload) begin
                    state_nxt = S_INIT;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_INIT;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy        = (state == S_INIT);
    assign wr.wr_ready = (state == S_IDLE) && !reload;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign chan_ok     = ({1'b0, wr.wr_chan} < NUM_CH);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= accept && !chan_ok;
        end
    end

`ifdef LPM_CONSTANT_BANK_SHADOW_EN
    logic commit_en;
    assign commit_en = commit && (state == S_IDLE);
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    for (genvar i = 0; i < lpm_channels; i++) begin : g_ch
        logic                 load_ch;
        logic                 hit;
        logic [lpm_width-1:0] live;
        logic [lpm_width-1:0] merged;

        assign load_ch = load && (idx == CHAN_W'(i));
        assign hit     = accept && (wr.wr_chan == CHAN_W'(i));

`ifdef LPM_CONSTANT_BANK_SHADOW_EN
        logic [lpm_width-1:0] shadow;
        logic [lpm_width-1:0] shadow_nxt;

        assign merged     = (shadow & ~wr.wr_mask) | (wr.wr_data & wr.wr_mask);
        assign shadow_nxt = hit ? merged : shadow;

        // commit uses shadow_nxt so a same-cycle write is included
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                shadow <= '0;
                live   <= '0;
            end else if (load_ch) begin
                shadow <= lpm_cvalue[i*lpm_width +: lpm_width];
                live   <= lpm_cvalue[i*lpm_width +: lpm_width];
            end else begin
                shadow <= shadow_nxt;
                if (commit_en) begin
                    live <= shadow_nxt;
                end
            end
        end
`else
        assign merged = (live & ~wr.wr_mask) | (wr.wr_data & wr.wr_mask);

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                live <= '0;
            end else if (load_ch) begin
                live <= lpm_cvalue[i*lpm_width +: lpm_width];
            end else if (hit) begin
                live <= merged;
            end
        end
`endif

        assign result[i*lpm_width +: lpm_width] = live;
    end

endmodule

`default_nettype wire

// File: tb/tb_lpm_constant_bank.sv
// ============================================================================
// Module   : tb_lpm_constant_bank
// Brief    : Directed self-checking bench: 4-channel bank plus a 3-channel bank
//            for out-of-range channel writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpm_constant_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        reload;
    logic        commit;
    logic [31:0] result;
    logic        busy;
    logic        wr_err;

    logic        reload3;
    logic        commit3;
    logic [23:0] result3;
    logic        busy3;
    logic        wr_err3;

    int checks = 0;
    int errors = 0;

    lpm_constant_bank_if #(.WIDTH(8), .CHAN_W(2)) wr4 ();
    lpm_constant_bank_if #(.WIDTH(8), .CHAN_W(2)) wr3 ();

    lpm_constant_bank #(
        .lpm_width    (8),
        .lpm_channels (4),
        .lpm_cvalue   (32'h44332211),
        .lpm_type     ("lpm_constant_bank")
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .reload  (reload),
        .commit  (commit),
        .wr      (wr4.slave),
        .result  (result),
        .busy    (busy),
        .wr_err  (wr_err)
    );

    lpm_constant_bank #(
        .lpm_width    (8),
        .lpm_channels (3),
        .lpm_cvalue   (24'h332211),
        .lpm_type     ("lpm_constant_bank")
    ) dut3 (
        .clock   (clk),
        .reset_n (reset_n),
        .reload  (reload3),
        .commit  (commit3),
        .wr      (wr3.slave),
        .result  (result3),
        .busy    (busy3),
        .wr_err  (wr_err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        reload       = 1'b0;
        commit       = 1'b0;
        wr4.wr_valid = 1'b0;
        wr4.wr_chan  = '0;
        wr4.wr_data  = '0;
        wr4.wr_mask  = '0;
        reload3      = 1'b0;
        commit3      = 1'b0;
        wr3.wr_valid = 1'b0;
        wr3.wr_chan  = '0;
        wr3.wr_data  = '0;
        wr3.wr_mask  = '0;

        // Reset state
        tick();
        tick();
        check("rst_result", result, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_wr_err", {31'b0, wr_err}, 32'h0);
        check("rst_ready", {31'b0, wr4.wr_ready}, 32'h0);

        // Init sequence
        reset_n = 1'b1;
        check("init_busy0", {31'b0, busy}, 32'h1);
        tick();
        check("init_r1", result, 32'h00000011);
        check("init_b1", {31'b0, busy}, 32'h1);
        tick();
        check("init_r2", result, 32'h00002211);
        tick();
        check("init_r3", result, 32'h00332211);
        check("init_b3", {31'b0, busy}, 32'h1);
        tick();
        check("init_r4", result, 32'h44332211);
        check("init_done_busy", {31'b0, busy}, 32'h0);
        check("init_done_ready", {31'b0, wr4.wr_ready}, 32'h1);
        check("init3_result", {8'h0, result3}, 32'h00332211);
        check("init3_busy", {31'b0, busy3}, 32'h0);

        // Full-mask then partial-mask writes (commit also set for the shadow build)
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd2; wr4.wr_data = 8'hAB; wr4.wr_mask = 8'hFF;
        commit = 1'b1;
        tick();
        check("wr_ch2_full", result, 32'h44AB2211);
        wr4.wr_chan = 2'd1; wr4.wr_data = 8'hCD; wr4.wr_mask = 8'h0F;
        tick();
        wr4.wr_valid = 1'b0; commit = 1'b0;
        check("wr_ch1_mask", result, 32'h44AB2D11);
        check("wr_no_err", {31'b0, wr_err}, 32'h0);

        // reload beats a same-cycle write
        reload = 1'b1;
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd3; wr4.wr_data = 8'h00; wr4.wr_mask = 8'hFF;
        commit = 1'b1;
        #1;
        check("reload_ready_low", {31'b0, wr4.wr_ready}, 32'h0);
        tick();
        reload = 1'b0; wr4.wr_valid = 1'b0; commit = 1'b0;
        check("reload_drop_wr", result, 32'h44AB2D11);
        check("reload_busy", {31'b0, busy}, 32'h1);
        tick();
        tick();
        check("reinit_ch1", result, 32'h44AB2211);

        // reload two cycles into INIT restarts at channel 0
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("restart_busy", {31'b0, busy}, 32'h1);
        check("restart_hold", result, 32'h44AB2211);
        tick();
        check("restart_b1", {31'b0, busy}, 32'h1);
        tick();
        check("restart_b2", {31'b0, busy}, 32'h1);
        tick();
        check("restart_b3", {31'b0, busy}, 32'h1);
        check("restart_r3", result, 32'h44332211);
        tick();
        check("restart_done", {31'b0, busy}, 32'h0);
        check("restart_final", result, 32'h44332211);

        // Reset in the middle of a write burst
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd3; wr4.wr_data = 8'h01; wr4.wr_mask = 8'hFF;
        commit = 1'b1;
        tick();
        check("burst_wr", result, 32'h01332211);
        wr4.wr_chan = 2'd0; wr4.wr_data = 8'h77;
        reset_n = 1'b0;
        tick();
        check("burst_rst_result", result, 32'h0);
        check("burst_rst_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b1; wr4.wr_valid = 1'b0; commit = 1'b0;
        tick();
        check("replay_r1", result, 32'h00000011);
        tick();
        tick();
        tick();
        check("replay_final", result, 32'h44332211);
        check("replay_busy", {31'b0, busy}, 32'h0);

        // 3-channel bank: out-of-range write, then a valid masked write
        wr3.wr_valid = 1'b1; wr3.wr_chan = 2'd3; wr3.wr_data = 8'hFF; wr3.wr_mask = 8'hFF;
        commit3 = 1'b1;
        #1;
        check("ch3_ready", {31'b0, wr3.wr_ready}, 32'h1);
        tick();
        wr3.wr_valid = 1'b0; commit3 = 1'b0;
        check("oob_err", {31'b0, wr_err3}, 32'h1);
        check("oob_result", {8'h0, result3}, 32'h00332211);
        tick();
        check("oob_err_clear", {31'b0, wr_err3}, 32'h0);
        wr3.wr_valid = 1'b1; wr3.wr_chan = 2'd2; wr3.wr_data = 8'hA5; wr3.wr_mask = 8'hF0;
        commit3 = 1'b1;
        tick();
        wr3.wr_valid = 1'b0; commit3 = 1'b0;
        check("ch3_wr_ok", {8'h0, result3}, 32'h00A32211);
        check("ch3_wr_no_err", {31'b0, wr_err3}, 32'h0);

`ifdef LPM_CONSTANT_BANK_SHADOW_EN
        // Shadow write, then commit, then write+commit together
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd0; wr4.wr_data = 8'h55; wr4.wr_mask = 8'hFF;
        tick();
        wr4.wr_valid = 1'b0;
        check("shadow_hidden", result, 32'h44332211);
        tick();
        check("shadow_still_hidden", result, 32'h44332211);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("shadow_commit", result, 32'h44332255);
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd3; wr4.wr_data = 8'h99; wr4.wr_mask = 8'hFF;
        commit = 1'b1;
        tick();
        wr4.wr_valid = 1'b0; commit = 1'b0;
        check("shadow_wr_commit", result, 32'h99332255);
`else
        // Without shadow, writes land directly and commit has no effect
        wr4.wr_valid = 1'b1; wr4.wr_chan = 2'd0; wr4.wr_data = 8'h55; wr4.wr_mask = 8'hFF;
        tick();
        wr4.wr_valid = 1'b0;
        check("direct_wr", result, 32'h44332255);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_noop", result, 32'h44332255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
